buffer_scheduler: RTL

- Parametrised successor to the fixed 4-channel, 6-entry read scheduler.
- Holds NCH per-channel FIFOs of DEPTH entries, each ENTRY_W bits wide; entry LSB is the validity bit, upper bits are payload.
- On each `tick` pulse (from the shared frequency divider), pops one entry from a channel chosen by occupancy under latency, reliability or automatic mode, and presents the payload on the display/output path.
- Adds push-side flow control, invalid-entry dropping and read/drop statistics.

---
 rtl/buffer_scheduler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/buffer_scheduler.sv
// Multi-channel FIFO read scheduler: on each tick pops the fullest non-empty channel,
// with tie-breaking set by latency/reliability/auto mode, and counts delivered/dropped entries.
module buffer_scheduler #(
    parameter int NCH       = 4,
    parameter int DEPTH     = 6,
    parameter int ENTRY_W   = 3,
    parameter int THRESHOLD = 3,
    parameter int CNT_W     = 8,
    localparam int OCC_W    = $clog2(DEPTH + 1),
    localparam int CH_W     = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [1:0]             mode_sel,
    input  logic [NCH-1:0]         push,
    input  logic [NCH*ENTRY_W-1:0] push_data,
    output logic [NCH-1:0]         push_ready,
    output logic [NCH*OCC_W-1:0]   occ,
    output logic                   out_valid,
    output logic [ENTRY_W-2:0]     out_data,
    output logic [CH_W-1:0]        out_ch,
    output logic                   mode_o,
    output logic [CNT_W-1:0]       read_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    // Push handshake: an entry is taken when push[i] and push_ready[i] are both high
    // on a rising clk edge; push_ready depends only on registered occupancy.
    logic [ENTRY_W-1:0] mem    [NCH][DEPTH];
    logic [PTR_W-1:0]   rd_ptr [NCH];
    logic [PTR_W-1:0]   wr_ptr [NCH];
    logic [OCC_W-1:0]   cnt    [NCH];

    logic [NCH-1:0]     push_ok;
    logic [NCH-1:0]     pop_dec;
    logic               any_thr;
    logic               lat_mode;
    logic               found;
    logic               pop_en;
    logic [OCC_W-1:0]   best;
    logic [CH_W-1:0]    sel_ch;
    logic [ENTRY_W-1:0] head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        any_thr = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cnt[i] >= OCC_W'(THRESHOLD)) any_thr = 1'b1;
        end
        lat_mode = mode_sel[1] ? any_thr : ~mode_sel[0];

        // Strict compare keeps the lowest index on ties, >= moves to the highest.
        found  = 1'b0;
        best   = '0;
        sel_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cnt[i] != '0) begin
                if (lat_mode ? (cnt[i] > best) : (cnt[i] >= best)) begin
                    found  = 1'b1;
                    best   = cnt[i];
                    sel_ch = CH_W'(i);
                end
            end
        end
        pop_en = tick && found;
        head   = mem[sel_ch][rd_ptr[sel_ch]];

        for (int i = 0; i < NCH; i++) begin
            push_ready[i]                = (cnt[i] != OCC_W'(DEPTH));
            push_ok[i]                   = push[i] && push_ready[i];
            pop_dec[i]                   = pop_en && (sel_ch == CH_W'(i));
            occ[i*OCC_W +: OCC_W]        = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push_ok[i]) mem[i][wr_ptr[i]] <= push_data[i*ENTRY_W +: ENTRY_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            mode_o    <= 1'b0;
            read_cnt  <= '0;
            drop_cnt  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push_ok[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (pop_dec[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                cnt[i] <= cnt[i] + OCC_W'(push_ok[i]) - OCC_W'(pop_dec[i]);
            end
            out_valid <= 1'b0;
            if (pop_en) begin
                out_ch <= sel_ch;
                mode_o <= ~lat_mode;
                if (head[0]) begin
                    out_valid <= 1'b1;
                    out_data  <= head[ENTRY_W-1:1];
                    read_cnt  <= read_cnt + 1'b1;
                end else begin
                    drop_cnt  <= drop_cnt + 1'b1;
                end
            end
        end
    end
endmodule
